// File: rtl/gen_pulso.sv
// Push-button conditioner: 2-flop synchroniser, tick-sampled debounce, one-cycle press pulse,
// plus CLK3/CLK4 divided square-wave outputs. Define RELEASE_PULSE_EN to also pulse on release.
`timescale 1ns / 1ps

module gen_pulso #(
    parameter int unsigned DIV3_HALF   = 500,
    parameter int unsigned DIV4_HALF   = 5,
    parameter int unsigned DEB_SAMPLES = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic KEY,
    output logic SALIDA,
    output logic CLK3,
    output logic CLK4
);

    localparam int unsigned C3W = (DIV3_HALF > 1) ? $clog2(DIV3_HALF) : 1;
    localparam int unsigned C4W = (DIV4_HALF > 1) ? $clog2(DIV4_HALF) : 1;
    localparam int unsigned DW  = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES) : 1;

    localparam logic [C3W-1:0] C3_LAST   = C3W'(DIV3_HALF - 1);
    localparam logic [C4W-1:0] C4_LAST   = C4W'(DIV4_HALF - 1);
    localparam logic [DW-1:0]  DCNT_LAST = DW'(DEB_SAMPLES - 1);

    logic [C3W-1:0] c3_q, c3_d;
    logic [C4W-1:0] c4_q, c4_d;
    logic [DW-1:0]  dcnt_q, dcnt_d;
    logic           clk3_q, clk3_d;
    logic           clk4_q, clk4_d;
    logic           sync1_q, key_s_q;
    logic           deb_q, deb_d;
    logic           deb_prev_q;
    logic           salida_q, salida_d;
    logic           wrap3, tick;

    always_comb begin
        wrap3  = (c3_q == C3_LAST);
        // Tick marks the wrap that is about to raise CLK3.
        tick   = wrap3 & ~clk3_q;
        c3_d   = wrap3 ? '0 : c3_q + 1'b1;
        clk3_d = clk3_q ^ wrap3;

        c4_d   = c4_q;
        clk4_d = clk4_q;
        if (tick) begin
            if (c4_q == C4_LAST) begin
                c4_d   = '0;
                clk4_d = ~clk4_q;
            end else begin
                c4_d = c4_q + 1'b1;
            end
        end

        deb_d  = deb_q;
        dcnt_d = dcnt_q;
        if (tick) begin
            if (key_s_q == deb_q) begin
                dcnt_d = '0;
            end else if (dcnt_q == DCNT_LAST) begin
                deb_d  = key_s_q;
                dcnt_d = '0;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
        end

`ifdef RELEASE_PULSE_EN
        salida_d = deb_q ^ deb_prev_q;
`else
        salida_d = deb_q & ~deb_prev_q;
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            c3_q       <= '0;
            c4_q       <= '0;
            dcnt_q     <= '0;
            clk3_q     <= 1'b0;
            clk4_q     <= 1'b0;
            sync1_q    <= 1'b0;
            key_s_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            salida_q   <= 1'b0;
        end else begin
            c3_q       <= c3_d;
            c4_q       <= c4_d;
            dcnt_q     <= dcnt_d;
            clk3_q     <= clk3_d;
            clk4_q     <= clk4_d;
            sync1_q    <= KEY;
            key_s_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            salida_q   <= salida_d;
        end
    end

    assign SALIDA = salida_q;
    assign CLK3   = clk3_q;
    assign CLK4   = clk4_q;

endmodule

// File: tb/tb_gen_pulso.sv
// Directed self-checking bench for gen_pulso at default parameters (10 MHz CLK).
`timescale 1ns / 1ps

module tb_gen_pulso;

    localparam int LAT_MIN = 3000;
    localparam int LAT_MAX = 4003;
`ifdef RELEASE_PULSE_EN
    localparam int REL_PULSES = 1;
`else
    localparam int REL_PULSES = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic key   = 1'b0;
    logic salida, clk3, clk4;

    int n_checks = 0;
    int n_errors = 0;
    int cyc, pulses, high_cnt, first_cyc;
    logic prev_sal;

    gen_pulso dut (
        .CLK   (clk),
        .RESET (rst_n),
        .KEY   (key),
        .SALIDA(salida),
        .CLK3  (clk3),
        .CLK4  (clk4)
    );

    always #50 clk = ~clk;

    task automatic clear_stats();
        cyc       = 0;
        pulses    = 0;
        high_cnt  = 0;
        first_cyc = -1;
        prev_sal  = salida;
    endtask

    // Advance n cycles, sampling SALIDA on each falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (salida === 1'b1) begin
                high_cnt++;
                if (prev_sal !== 1'b1) begin
                    pulses++;
                    if (first_cyc < 0) first_cyc = cyc;
                end
            end
            prev_sal = salida;
        end
    endtask

    task automatic test_reset();
        int bad_s, bad_3, bad_4;
        bad_s = 0; bad_3 = 0; bad_4 = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (i % 37 == 0) key = ~key;
            if (salida !== 1'b0) bad_s++;
            if (clk3 !== 1'b0) bad_3++;
            if (clk4 !== 1'b0) bad_4++;
        end
        n_checks++;
        if (bad_s !== 0) begin n_errors++; $display("FAIL reset_salida: %0d cycles high, want 0", bad_s); end
        n_checks++;
        if (bad_3 !== 0) begin n_errors++; $display("FAIL reset_clk3: %0d cycles high, want 0", bad_3); end
        n_checks++;
        if (bad_4 !== 0) begin n_errors++; $display("FAIL reset_clk4: %0d cycles high, want 0", bad_4); end
    endtask

    task automatic test_clocks();
        int r3a, f3a, r3b, r4a, f4a;
        logic p3, p4;
        r3a = -1; f3a = -1; r3b = -1; r4a = -1; f4a = -1;
        key   = 1'b0;
        rst_n = 1'b1;
        clear_stats();
        p3 = 1'b0; p4 = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            step(1);
            if (clk3 === 1'b1 && p3 === 1'b0) begin
                if (r3a < 0) r3a = cyc; else if (r3b < 0) r3b = cyc;
            end
            if (clk3 === 1'b0 && p3 === 1'b1 && f3a < 0) f3a = cyc;
            if (clk4 === 1'b1 && p4 === 1'b0 && r4a < 0) r4a = cyc;
            if (clk4 === 1'b0 && p4 === 1'b1 && f4a < 0) f4a = cyc;
            p3 = clk3;
            p4 = clk4;
        end
        n_checks++;
        if (r3a !== 500) begin n_errors++; $display("FAIL clk3_first_rise: got %0d want 500", r3a); end
        n_checks++;
        if (f3a !== 1000) begin n_errors++; $display("FAIL clk3_first_fall: got %0d want 1000", f3a); end
        n_checks++;
        if (r3b !== 1500) begin n_errors++; $display("FAIL clk3_second_rise: got %0d want 1500", r3b); end
        n_checks++;
        if (r4a !== 4500) begin n_errors++; $display("FAIL clk4_first_rise: got %0d want 4500", r4a); end
        n_checks++;
        if (f4a !== 9500) begin n_errors++; $display("FAIL clk4_first_fall: got %0d want 9500", f4a); end
        n_checks++;
        if (pulses !== 0) begin n_errors++; $display("FAIL idle_salida: %0d pulses want 0", pulses); end
    endtask

    task automatic test_glitch();
        key = 1'b1;
        clear_stats();
        step(10);
        key = 1'b0;
        step(5000);
        n_checks++;
        if (pulses !== 0) begin n_errors++; $display("FAIL glitch: %0d pulses want 0", pulses); end
    endtask

    task automatic test_press();
        key = 1'b1;
        clear_stats();
        step(8000);
        n_checks++;
        if (pulses !== 1) begin n_errors++; $display("FAIL press_count: %0d pulses want 1", pulses); end
        n_checks++;
        if (high_cnt !== 1) begin n_errors++; $display("FAIL press_width: %0d high cycles want 1", high_cnt); end
        n_checks++;
        if (first_cyc < LAT_MIN || first_cyc > LAT_MAX) begin
            n_errors++;
            $display("FAIL press_latency: got %0d want %0d..%0d", first_cyc, LAT_MIN, LAT_MAX);
        end
        key = 1'b0;
        clear_stats();
        step(6000);
        n_checks++;
        if (pulses !== REL_PULSES) begin
            n_errors++;
            $display("FAIL release_count: %0d pulses want %0d", pulses, REL_PULSES);
        end
        if (REL_PULSES == 1) begin
            n_checks++;
            if (first_cyc < LAT_MIN || first_cyc > LAT_MAX) begin
                n_errors++;
                $display("FAIL release_latency: got %0d want %0d..%0d", first_cyc, LAT_MIN, LAT_MAX);
            end
        end
    endtask

    task automatic test_bounce();
        clear_stats();
        for (int seg = 0; seg < 10; seg++) begin
            key = (seg % 2 == 0);
            step(200);
        end
        key = 1'b1;
        step(8000);
        n_checks++;
        if (pulses !== 1) begin n_errors++; $display("FAIL bounce_count: %0d pulses want 1", pulses); end
        n_checks++;
        if (high_cnt !== 1) begin n_errors++; $display("FAIL bounce_width: %0d high cycles want 1", high_cnt); end
        n_checks++;
        if (first_cyc <= 2000) begin
            n_errors++;
            $display("FAIL bounce_timing: pulse at %0d want after 2000", first_cyc);
        end
        key = 1'b0;
        clear_stats();
        step(6000);
        n_checks++;
        if (pulses !== REL_PULSES) begin
            n_errors++;
            $display("FAIL bounce_release: %0d pulses want %0d", pulses, REL_PULSES);
        end
    endtask

    task automatic test_reset_mid();
        key = 1'b1;
        clear_stats();
        step(2000);
        n_checks++;
        if (pulses !== 0) begin n_errors++; $display("FAIL mid_pre_reset: %0d pulses want 0", pulses); end
        rst_n = 1'b0;
        clear_stats();
        step(10);
        n_checks++;
        if (pulses !== 0) begin n_errors++; $display("FAIL mid_in_reset: %0d pulses want 0", pulses); end
        n_checks++;
        if (clk3 !== 1'b0) begin n_errors++; $display("FAIL mid_clk3: got %b want 0", clk3); end
        rst_n = 1'b1;
        clear_stats();
        step(6000);
        n_checks++;
        if (pulses !== 1) begin n_errors++; $display("FAIL mid_count: %0d pulses want 1", pulses); end
        n_checks++;
        if (high_cnt !== 1) begin n_errors++; $display("FAIL mid_width: %0d high cycles want 1", high_cnt); end
        n_checks++;
        if (first_cyc !== 3501) begin n_errors++; $display("FAIL mid_latency: got %0d want 3501", first_cyc); end
        key = 1'b0;
        clear_stats();
        step(6000);
        n_checks++;
        if (pulses !== REL_PULSES) begin
            n_errors++;
            $display("FAIL mid_release: %0d pulses want %0d", pulses, REL_PULSES);
        end
    endtask

    initial begin
        test_reset();
        test_clocks();
        test_glitch();
        test_press();
        test_bounce();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
